// File: rtl/fifo_uart_tx.sv
// Drains 32-bit words from the peripheral FIFO and transmits them as four
// UART 8N1/8N2 frames, least-significant byte first.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [31:0]       word_q;
  logic [7:0]        shift_q;
  logic [1:0]        byte_q;
  logic [2:0]        bit_q;
  logic [BAUD_W-1:0] baud_q;
  logic              bit_end;
  logic [7:0]        next_byte;

  assign bit_end = (baud_q == BAUD_LAST);

  // Byte that follows the one currently on the line
  always_comb begin
    case (byte_q)
      2'd0:    next_byte = word_q[15:8];
      2'd1:    next_byte = word_q[23:16];
      2'd2:    next_byte = word_q[31:24];
      default: next_byte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      word_done  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state_q    <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          word_q  <= fifo_dout;
          shift_q <= fifo_dout[7:0];
          byte_q  <= '0;
          bit_q   <= '0;
          baud_q  <= '0;
          tx      <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx      <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              tx      <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx      <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (byte_q != 2'd3) begin
                byte_q  <= byte_q + 2'd1;
                shift_q <= next_byte;
                tx      <= 1'b0;
                state_q <= START;
              end else begin
                state_q   <= IDLE;
                busy      <= 1'b0;
                word_done <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one DUT with 1 stop bit, one with 2 stop bits,
// both at 4 clocks per bit, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en1, en2;
  logic        empty1, empty2;
  logic [31:0] dout1 = '0, dout2 = '0;
  logic        rd1, rd2, tx1, tx2, busy1, busy2, done1, done2;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  assign empty1 = (q1.size() == 0);
  assign empty2 = (q2.size() == 0);

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .word_done(done1));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .word_done(done2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read ports: dout valid the cycle after a pop
  always @(posedge clk) begin
    if (rd1 === 1'b1 && q1.size() > 0) dout1 <= q1.pop_front();
    if (rd2 === 1'b1 && q2.size() > 0) dout2 <= q2.pop_front();
  end

  logic tx1_h [4096];
  logic busy1_h [4096];
  logic tx2_h [4096];
  int rd1_q[$], done1_q[$], rd2_q[$], done2_q[$];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      tx1_h[cyc]   = tx1;
      busy1_h[cyc] = busy1;
      tx2_h[cyc]   = tx2;
    end
    if (rd1 === 1'b1)   rd1_q.push_back(cyc);
    if (done1 === 1'b1) done1_q.push_back(cyc);
    if (rd2 === 1'b1)   rd2_q.push_back(cyc);
    if (done2 === 1'b1) done2_q.push_back(cyc);
  end

  int compared = 0;
  int mismatched = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic hist(input bit two, input int idx);
    if (idx < 0 || idx >= 4096) return 1'bx;
    return two ? tx2_h[idx] : tx1_h[idx];
  endfunction

  function automatic int first_low(input bit two, input int from);
    for (int k = from; k < from + 400; k++)
      if (hist(two, k) === 1'b0) return k;
    return -1;
  endfunction

  // Returns {framing_ok, word} by sampling the middle of each bit
  function automatic logic [32:0] decode(input bit two, input int s);
    logic [31:0] w;
    logic        ok;
    int          frame;
    int          nbits;
    logic        v;
    w = '0;
    ok = 1'b1;
    frame = two ? 44 : 40;
    nbits = two ? 11 : 10;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < nbits; j++) begin
        v = hist(two, s + frame * b + 4 * j + 2);
        if (j == 0) ok = ok & (v === 1'b0);
        else if (j <= 8) w[8 * b + j - 1] = v;
        else ok = ok & (v === 1'b1);
      end
    end
    return {ok, w};
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0;
    @(negedge clk);
    q1.push_back(32'hA5C30F81);
    en1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      compared++; if (tx1 !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b want 1", tx1); end
      compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy1); end
      compared++; if (rd1 !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en: got %b want 0", rd1); end
      compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL reset_word_done: got %b want 0", done1); end
    end
    en1 = 1'b0;
    rst = 1'b0;
    tick(5);
    compared++; if (rd1_q.size() != 0) begin mismatched++; $display("FAIL reset_no_pop: got %0d pops want 0", rd1_q.size()); end
  endtask

  task automatic test_single_word();
    int t0;
    logic [32:0] d;
    rd1_q.delete(); done1_q.delete();
    t0 = cyc;
    en1 = 1'b1;
    tick(170);
    en1 = 1'b0;
    compared++; if (rd1_q.size() != 1) begin mismatched++; $display("FAIL single_pop_count: got %0d want 1", rd1_q.size()); end
    compared++; if (qget(rd1_q, 0) != t0 + 1) begin mismatched++; $display("FAIL single_pop_cycle: got %0d want %0d", qget(rd1_q, 0), t0 + 1); end
    compared++; if (first_low(0, t0) != t0 + 3) begin mismatched++; $display("FAIL single_start: got %0d want %0d", first_low(0, t0), t0 + 3); end
    compared++; if (done1_q.size() != 1 || qget(done1_q, 0) != t0 + 163) begin mismatched++; $display("FAIL single_done: got %0d (n=%0d) want %0d", qget(done1_q, 0), done1_q.size(), t0 + 163); end
    compared++; if (busy1_h[t0 + 1] !== 1'b1 || busy1_h[t0 + 162] !== 1'b1) begin mismatched++; $display("FAIL single_busy_high: got %b/%b want 1/1", busy1_h[t0 + 1], busy1_h[t0 + 162]); end
    compared++; if (busy1_h[t0] !== 1'b0 || busy1_h[t0 + 163] !== 1'b0) begin mismatched++; $display("FAIL single_busy_low: got %b/%b want 0/0", busy1_h[t0], busy1_h[t0 + 163]); end
    d = decode(0, t0 + 3);
    compared++; if (d !== {1'b1, 32'hA5C30F81}) begin mismatched++; $display("FAIL single_bytes: got %h want %h", d, {1'b1, 32'hA5C30F81}); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int highs;
    logic [32:0] d;
    rd1_q.delete(); done1_q.delete();
    q1.push_back(32'h00000001);
    q1.push_back(32'hFFFFFFFE);
    t0 = cyc;
    en1 = 1'b1;
    tick(340);
    en1 = 1'b0;
    compared++; if (rd1_q.size() != 2) begin mismatched++; $display("FAIL b2b_pop_count: got %0d want 2", rd1_q.size()); end
    compared++; if (qget(rd1_q, 1) - qget(rd1_q, 0) != 163) begin mismatched++; $display("FAIL b2b_pop_gap: got %0d want 163", qget(rd1_q, 1) - qget(rd1_q, 0)); end
    highs = 0;
    for (int k = t0 + 163; k <= t0 + 165; k++) if (tx1_h[k] === 1'b1) highs++;
    compared++; if (highs != 3 || tx1_h[t0 + 166] !== 1'b0 || tx1_h[t0 + 162] !== 1'b1) begin mismatched++; $display("FAIL b2b_gap: got %0d high, next start %b want 3 high, start 0", highs, tx1_h[t0 + 166]); end
    d = decode(0, t0 + 3);
    compared++; if (d !== {1'b1, 32'h00000001}) begin mismatched++; $display("FAIL b2b_word0: got %h want %h", d, {1'b1, 32'h00000001}); end
    d = decode(0, t0 + 166);
    compared++; if (d !== {1'b1, 32'hFFFFFFFE}) begin mismatched++; $display("FAIL b2b_word1: got %h want %h", d, {1'b1, 32'hFFFFFFFE}); end
    compared++; if (done1_q.size() != 2 || qget(done1_q, 1) != t0 + 326) begin mismatched++; $display("FAIL b2b_done: got %0d (n=%0d) want %0d", qget(done1_q, 1), done1_q.size(), t0 + 326); end
  endtask

  task automatic test_enable_gating();
    int g0, t0, lows;
    logic [32:0] d;
    rd1_q.delete(); done1_q.delete();
    g0 = cyc;
    q1.push_back(32'h12345678);
    tick(50);
    lows = 0;
    for (int k = g0; k < cyc; k++) if (tx1_h[k] !== 1'b1) lows++;
    compared++; if (rd1_q.size() != 0) begin mismatched++; $display("FAIL gate_no_pop: got %0d pops want 0", rd1_q.size()); end
    compared++; if (lows != 0) begin mismatched++; $display("FAIL gate_tx_idle: got %0d non-high cycles want 0", lows); end
    t0 = cyc;
    en1 = 1'b1;
    tick(50);
    en1 = 1'b0;
    q1.push_back(32'hDEADBEEF);
    tick(150);
    compared++; if (rd1_q.size() != 1 || qget(rd1_q, 0) != t0 + 1) begin mismatched++; $display("FAIL gate_pop: got %0d (n=%0d) want %0d", qget(rd1_q, 0), rd1_q.size(), t0 + 1); end
    compared++; if (done1_q.size() != 1 || qget(done1_q, 0) != t0 + 163) begin mismatched++; $display("FAIL gate_done: got %0d (n=%0d) want %0d", qget(done1_q, 0), done1_q.size(), t0 + 163); end
    d = decode(0, t0 + 3);
    compared++; if (d !== {1'b1, 32'h12345678}) begin mismatched++; $display("FAIL gate_word: got %h want %h", d, {1'b1, 32'h12345678}); end
    compared++; if (q1.size() != 1) begin mismatched++; $display("FAIL gate_fifo_left: got %0d words want 1", q1.size()); end
  endtask

  task automatic test_reset_mid();
    int t0, r0;
    logic [32:0] d;
    rd1_q.delete(); done1_q.delete();
    q1.push_back(32'hCAFE0042);
    t0 = cyc;
    en1 = 1'b1;
    tick(100);
    compared++; if (busy1 !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b want 1", busy1); end
    rst = 1'b1;
    tick(1);
    compared++; if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0 || done1 !== 1'b0) begin mismatched++; $display("FAIL mid_reset_outputs: got tx=%b busy=%b rd=%b done=%b want 1 0 0 0", tx1, busy1, rd1, done1); end
    rst = 1'b0;
    r0 = cyc;
    tick(170);
    en1 = 1'b0;
    compared++; if (rd1_q.size() != 2 || qget(rd1_q, 1) != r0 + 1) begin mismatched++; $display("FAIL mid_restart_pop: got %0d (n=%0d) want %0d", qget(rd1_q, 1), rd1_q.size(), r0 + 1); end
    compared++; if (first_low(0, r0) != r0 + 3) begin mismatched++; $display("FAIL mid_restart_start: got %0d want %0d", first_low(0, r0), r0 + 3); end
    compared++; if (done1_q.size() != 1 || qget(done1_q, 0) != r0 + 163) begin mismatched++; $display("FAIL mid_done: got %0d (n=%0d) want %0d", qget(done1_q, 0), done1_q.size(), r0 + 163); end
    d = decode(0, r0 + 3);
    compared++; if (d !== {1'b1, 32'hCAFE0042}) begin mismatched++; $display("FAIL mid_word: got %h want %h", d, {1'b1, 32'hCAFE0042}); end
  endtask

  task automatic test_two_stop();
    int t0, s;
    logic ok;
    logic [32:0] d;
    rd2_q.delete(); done2_q.delete();
    q2.push_back(32'h5A3C9601);
    t0 = cyc;
    en2 = 1'b1;
    tick(190);
    en2 = 1'b0;
    s = t0 + 3;
    compared++; if (rd2_q.size() != 1 || qget(rd2_q, 0) != t0 + 1) begin mismatched++; $display("FAIL stop2_pop: got %0d (n=%0d) want %0d", qget(rd2_q, 0), rd2_q.size(), t0 + 1); end
    compared++; if (first_low(1, t0) != s) begin mismatched++; $display("FAIL stop2_start: got %0d want %0d", first_low(1, t0), s); end
    ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 36; k < 44; k++) ok = ok & (tx2_h[s + 44 * b + k] === 1'b1);
      if (b < 3) ok = ok & (tx2_h[s + 44 * b + 44] === 1'b0);
    end
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL stop2_phase: got %b want 1 (8 high cycles then start)", ok); end
    compared++; if (done2_q.size() != 1 || qget(done2_q, 0) != t0 + 179) begin mismatched++; $display("FAIL stop2_done: got %0d (n=%0d) want %0d", qget(done2_q, 0), done2_q.size(), t0 + 179); end
    d = decode(1, s);
    compared++; if (d !== {1'b1, 32'h5A3C9601}) begin mismatched++; $display("FAIL stop2_word: got %h want %h", d, {1'b1, 32'h5A3C9601}); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid();
    test_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
